// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - bus-mapped GPIO, compare-match timer and buffered UART transmitter
module mmio_responder #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            write_en,
    input  logic [31:0]           addr,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  uart_tx,
    output logic                  irq
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] we);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (we[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    logic [2:0]            sel;
    logic                  wr_any;
    logic [GPIO_WIDTH-1:0] gpio_meta, gpio_sync;
    logic [31:0]           gpio_wr, rdata_mux;
    logic [31:0]           count, cmp, count_next;
    logic                  t_en, t_ie, pending;
    logic                  match, ctrl_wr, en_next, ie_next, pend_next;
    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           occ;
    logic                  full, empty, push, pop, busy;
    state_t                state;
    logic [15:0]           baud;
    logic                  baud_end;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;

    assign sel      = addr[4:2];
    assign wr_any   = en && (write_en != 4'b0000);
    assign gpio_wr  = lane_merge(32'(gpio_out), write_data, write_en);
    assign full     = (occ == (PW+1)'(FIFO_DEPTH));
    assign empty    = (occ == '0);
    assign busy     = (state != S_IDLE);
    assign push     = en && (sel == 3'd5) && write_en[0] && !full;
    assign pop      = (state == S_IDLE) && !empty;
    assign baud_end = (baud == 16'(CLK_DIV - 1));

    always_comb begin
        rdata_mux = 32'd0;
        case (sel)
            3'd0: rdata_mux = 32'(gpio_out);
            3'd1: rdata_mux = 32'(gpio_sync);
            3'd2: rdata_mux = count;
            3'd3: rdata_mux = cmp;
            3'd4: rdata_mux = {29'd0, pending, t_ie, t_en};
            3'd6: rdata_mux = {29'd0, busy, empty, full};
            default: rdata_mux = 32'd0;
        endcase
    end

    // A bus write to COUNT beats the free-running increment; a new match beats a pending clear.
    always_comb begin
        match      = t_en && (count == cmp);
        ctrl_wr    = en && (sel == 3'd4) && write_en[0];
        count_next = count;
        if (wr_any && sel == 3'd2)
            count_next = lane_merge(count, write_data, write_en);
        else if (t_en)
            count_next = match ? 32'd0 : count + 32'd1;
        en_next   = ctrl_wr ? write_data[0] : t_en;
        ie_next   = ctrl_wr ? write_data[1] : t_ie;
        pend_next = match ? 1'b1 : ((ctrl_wr && write_data[2]) ? 1'b0 : pending);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= 32'd0;
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
            count     <= 32'd0;
            cmp       <= 32'hFFFF_FFFF;
            t_en      <= 1'b0;
            t_ie      <= 1'b0;
            pending   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (en) read_data <= rdata_mux;
            if (wr_any && sel == 3'd0) gpio_out <= gpio_wr[GPIO_WIDTH-1:0];
            if (wr_any && sel == 3'd3) cmp <= lane_merge(cmp, write_data, write_en);
            count   <= count_next;
            t_en    <= en_next;
            t_ie    <= ie_next;
            pending <= pend_next;
            irq     <= pend_next & ie_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud    <= 16'd0;
                    uart_tx <= 1'b1;
                    if (!empty) begin
                        shreg   <= fifo_mem[rd_ptr];
                        state   <= S_START;
                        uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud    <= 16'd0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                        uart_tx <= shreg[0];
                    end else baud <= baud + 16'd1;
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            uart_tx <= shreg[1];
                        end
                    end else baud <= baud + 16'd1;
                end
                default: begin
                    if (baud_end) begin
                        baud  <= 16'd0;
                        state <= S_IDLE;
                    end else baud <= baud + 16'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - randomized and directed checks of mmio_responder against a frame-level model
module tb_mmio_responder;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int GW      = 16;
    localparam int FR      = 10 * CLK_DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    write_en;
    logic [31:0]   addr, write_data, read_data;
    logic [GW-1:0] gpio_in, gpio_out;
    logic          uart_tx, irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_rd, m_gpio, m_count, m_cmp;
    logic        m_en, m_ie, m_pend;
    logic [7:0]  q[$];
    logic [7:0]  m_cur;
    int          m_t;
    logic [GW-1:0] m_g1, m_g2;

    mmio_responder #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .GPIO_WIDTH(GW)) dut (
        .clk(clk), .rst(rst), .en(en), .write_en(write_en), .addr(addr),
        .write_data(write_data), .read_data(read_data), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (we[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Frame timeline: m_t cycles since the byte was taken; bit slot = m_t / CLK_DIV.
    function automatic logic exp_tx();
        int ph;
        if (m_t >= FR) return 1'b1;
        ph = m_t / CLK_DIV;
        if (ph == 0) return 1'b0;
        if (ph == 9) return 1'b1;
        return m_cur[ph-1];
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] idx);
        case (idx)
            3'd0: return m_gpio;
            3'd1: return 32'(m_g2);
            3'd2: return m_count;
            3'd3: return m_cmp;
            3'd4: return {29'd0, m_pend, m_ie, m_en};
            3'd6: return {29'd0, m_t < FR, q.size() == 0, q.size() == DEPTH};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_rd = 0; m_gpio = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
        m_en = 0; m_ie = 0; m_pend = 0;
        q.delete(); m_cur = 0; m_t = FR; m_g1 = 0; m_g2 = 0;
    endtask

    task automatic model_step();
        logic [2:0]  idx;
        logic        match, clr, busy0;
        int          size0;
        logic [31:0] nc;
        idx   = addr[4:2];
        size0 = q.size();
        busy0 = (m_t < FR);
        if (en) m_rd = reg_val(idx);
        match = m_en && (m_count == m_cmp);
        nc = m_en ? (match ? 32'd0 : 32'(m_count + 1)) : m_count;
        if (en && idx == 3'd2 && write_en != 0) nc = merge(m_count, write_data, write_en);
        m_count = nc;
        if (en && idx == 3'd0) m_gpio = merge(m_gpio, write_data, write_en) & 32'h0000_FFFF;
        if (en && idx == 3'd3) m_cmp = merge(m_cmp, write_data, write_en);
        clr = 0;
        if (en && idx == 3'd4 && write_en[0]) begin
            m_en = write_data[0]; m_ie = write_data[1]; clr = write_data[2];
        end
        if (match) m_pend = 1;
        else if (clr) m_pend = 0;
        if (busy0) m_t++;
        else if (size0 > 0) begin
            m_cur = q.pop_front();
            m_t = 0;
        end
        if (en && idx == 3'd5 && write_en[0] && size0 < DEPTH) q.push_back(write_data[7:0]);
        m_g2 = m_g1;
        m_g1 = gpio_in;
    endtask

    task automatic bus(input logic e, input logic [3:0] we, input logic [2:0] idx, input logic [31:0] d);
        en = e; write_en = we; write_data = d;
        addr = ($urandom() & 32'hFFFF_FFE0) | {27'd0, idx, 2'b00} | 32'($urandom_range(0, 3));
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("read_data", read_data, m_rd);
        chk("gpio_out", 32'(gpio_out), m_gpio);
        chk("irq", 32'(irq), 32'(m_pend & m_ie));
        chk("uart_tx", 32'(uart_tx), 32'(exp_tx()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(0, 4'h0, 3'd7, 32'd0);
    endtask

    initial begin
        logic [31:0] seq [5];
        int nbusy;
        logic [2:0] ridx;
        logic [31:0] rdat;
        seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        rst = 1; en = 0; write_en = 0; addr = 0; write_data = 0; gpio_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_gpio", 32'(gpio_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_rd", read_data, 32'd0);
        bus(1, 4'h0, 3'd3, 32'd0);
        chk("rst_cmp", read_data, 32'hFFFF_FFFF);

        bus(1, 4'b0011, 3'd0, 32'h1234_5678);
        chk("gpio_lane", 32'(gpio_out), 32'h5678);
        bus(1, 4'b1111, 3'd0, 32'hFFFF_0000);
        chk("gpio_full", 32'(gpio_out), 32'h0);
        chk("rd_old", read_data, 32'h5678);

        bus(1, 4'hF, 3'd3, 32'd3);
        bus(1, 4'hF, 3'd2, 32'd0);
        bus(1, 4'h1, 3'd4, 32'd3);
        for (int i = 0; i < 5; i++) begin
            bus(1, 4'h0, 3'd2, 32'd0);
            chk("tmr_seq", read_data, seq[i]);
            chk("tmr_irq", 32'(irq), 32'(i >= 3));
        end
        bus(1, 4'h0, 3'd4, 32'd4);
        chk("ctrl_we0", 32'(irq), 32'd1);
        bus(1, 4'h1, 3'd4, 32'd4);
        chk("ctrl_clr", 32'(irq), 32'd0);

        bus(1, 4'hF, 3'd2, 32'd0);
        bus(1, 4'h1, 3'd4, 32'd3);
        idle(3);
        bus(1, 4'hF, 3'd2, 32'd10);
        bus(1, 4'h0, 3'd2, 32'd0);
        chk("prio_cnt", read_data, 32'd10);
        chk("prio_irq", 32'(irq), 32'd1);
        bus(1, 4'h1, 3'd4, 32'd4);

        bus(1, 4'h1, 3'd5, 32'h0000_00A5);
        nbusy = 0;
        for (int i = 0; i < 45; i++) begin
            bus(1, 4'h0, 3'd6, 32'd0);
            nbusy += int'(read_data[2]);
        end
        chk("busy_len", nbusy, 32'd40);

        for (int i = 0; i < 6; i++) bus(1, 4'h1, 3'd5, 32'(8'h30 + i));
        bus(1, 4'h0, 3'd6, 32'd0);
        chk("fifo_full", 32'(read_data[0]), 32'd1);
        idle(5 * (FR + 1) + 10);
        bus(1, 4'h0, 3'd6, 32'd0);
        chk("fifo_drain", read_data, 32'h2);

        bus(1, 4'h3, 3'd0, 32'h0000_BEEF);
        bus(1, 4'hF, 3'd3, 32'd0);
        bus(1, 4'h1, 3'd4, 32'd3);
        bus(1, 4'h1, 3'd5, 32'd0);
        idle(6);
        #2 rst = 1;
        #1;
        chk("arst_tx", 32'(uart_tx), 32'd1);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_gpio", 32'(gpio_out), 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        bus(1, 4'h0, 3'd3, 32'd0);
        chk("arst_cmp", read_data, 32'hFFFF_FFFF);
        bus(1, 4'h0, 3'd6, 32'd0);
        chk("arst_stat", read_data, 32'h2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) gpio_in = GW'($urandom());
            ridx = 3'($urandom_range(0, 7));
            rdat = (ridx == 3'd2 || ridx == 3'd3) ? 32'($urandom_range(0, 20)) : $urandom();
            bus($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'h0, ridx, rdat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped peripheral responder on the core's RAM-side bus (en / byte write_en / addr / write_data / read_data).
- Answers loads and stores from the core with the same one-cycle synchronous read latency as block RAM.
- Contains a GPIO port, a compare-match timer with interrupt, and a FIFO-buffered 8N1 UART transmitter.
- Sits behind the system address decoder; only asserted `en` cycles reach it.

Parameters:
- CLK_DIV, 16: clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4: UART TX FIFO entries; power of two, minimum 2.
- GPIO_WIDTH, 16: width of gpio_out and gpio_in; legal range 1..32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  bus access strobe for this cycle
- write_en  input  4  byte write enables; 0000 with en=1 means read
- addr  input  32  byte address; only addr[4:2] decoded
- write_data  input  32  store data
- read_data  output  32  load data, registered
- gpio_in  input  GPIO_WIDTH  external switch inputs, asynchronous
- gpio_out  output  GPIO_WIDTH  LED/output register
- uart_tx  output  1  serial out, idle high
- irq  output  1  timer interrupt, level

Behaviour:
- Register map (offset = addr[4:2]*4):
  - 0x00 GPIO_OUT: read/write.
  - 0x04 GPIO_IN: read-only; value after 2-flop synchronizer, zero-extended.
  - 0x08 TIMER_COUNT: read/write.
  - 0x0C TIMER_CMP: read/write.
  - 0x10 TIMER_CTRL: bit0 enable, bit1 irq_en, bit2 pending (write 1 clears).
  - 0x14 UART_DATA: write pushes write_data[7:0]; reads 0.
  - 0x18 UART_STATUS: bit0 full, bit1 empty, bit2 busy; read-only.
  - 0x1C: reserved; reads 0, writes ignored.
- Reads:
  - When en=1, read_data is loaded at the clock edge with the addressed register's value as of before that edge.
  - This happens regardless of write_en; a simultaneous write does not affect the returned value.
  - When en=0, read_data holds its previous value.
- Writes:
  - Occur only when en=1; each byte lane is gated by write_en[i].
  - Within GPIO_OUT, bits at or above GPIO_WIDTH are ignored.
  - TIMER_CTRL and UART_DATA act only when write_en[0]=1; their other lanes are ignored.
- Reset values: read_data=0, gpio_out=0, count=0, cmp=0xFFFFFFFF, ctrl=0, FIFO empty, UART state IDLE, uart_tx=1, irq=0.
- Timer:
  - While enable=1, each cycle: if count==cmp, count becomes 0 and pending is set; otherwise count increments by 1, mod 2^32.
  - A bus write to COUNT takes priority over increment/wrap in the same cycle.
  - If a clear of pending and a new match occur in the same cycle, set wins.
  - irq = pending & irq_en, registered in the pending flop path; no extra delay beyond pending.
- UART FIFO:
  - Circular buffer with read/write pointers and occupancy count.
  - A push when full is dropped silently.
  - Push and pop in the same cycle are both honoured.
  - Status flags are computed from the registered occupancy.
- UART FSM:
  - IDLE: if FIFO non-empty, pop a byte into the shift register and go to START; the pop happens in the IDLE→START cycle.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each.
  - STOP: tx=1 for CLK_DIV cycles, then back to IDLE, which may pop again on the next cycle.
  - busy = (state != IDLE).
  - Baud counter counts 0..CLK_DIV-1 and resets on every state change.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously); FIFO contents are discarded.

Test Plan:
- Reset: assert rst mid-UART-frame → uart_tx=1, irq=0, gpio_out=0, read of 0x0C returns 0xFFFFFFFF one cycle after en.
- Byte-lane write: write 0x12345678 to 0x00 with write_en=0011 after reset → gpio_out=0x5678; write write_en=1111 with data 0xFFFF0000 → gpio_out=0x0000; a read issued in the same cycle as the write returns the old value.
- Timer: cmp=3, ctrl=0b011 → count sequence 0,1,2,3,0; pending and irq rise on the wrap edge. Writing 0x4 to ctrl clears irq; with write_en=0000 nothing changes.
- Timer priority: write COUNT=10 in a cycle where count==cmp → count=10, pending still set.
- UART: CLK_DIV=4, push 0xA5 → uart_tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each bit 4 cycles; busy high for 40 cycles.
- FIFO: push 6 bytes back-to-back with FIFO_DEPTH=4 while idle → 1 popped immediately and 4 buffered, so the 6th push is dropped; full=1 after the 5th push. Exactly 5 frames are transmitted, then empty=1 and busy=0.
